// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one SRAM-like req/addr_ok/data_ok memory bus between the instruction
// fetch port and the data port of the pipelined MIPS core. It grants one master
// at a time and runs a single outstanding transaction. Read data comes back with
// a one-cycle done pulse. A transfer that hangs is aborted with a timeout error.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   i_req, i_addr            fetch request (level, held until i_done) and address
//   i_rdata, i_done          fetch read data (held) and one-cycle completion pulse
//   d_req, d_wr, d_sel,      data request (level), store flag, byte enables,
//   d_addr, d_wdata          address and store data
//   d_rdata, d_done          load data (held) and one-cycle completion pulse
//   m_req, m_wr, m_sel,      bus command; registered at grant and stable
//   m_addr, m_wdata          while m_req is high
//   m_addr_ok, m_data_ok,    bus handshake and read data
//   m_rdata
//   bus_err                  pulses together with the done of an aborted transfer
//   busy                     arbiter is not idle
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter bit RR     = 1'b1,  // 1: round-robin on contention, 0: data port wins
  parameter int TO_MAX = 255,   // REQ+WAIT cycles before abort (>= 2)
  parameter int TO_W   = 8      // timeout counter width, 2**TO_W > TO_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_req,
  output logic        m_wr,
  output logic [3:0]  m_sel,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        bus_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter value in the last REQ/WAIT cycle that is still allowed to finish.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_MAX - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  state_t          r_state;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_prefer_fetch;  // round-robin pointer: 1 = fetch wins next tie
  logic            r_owner_d;       // 1 = current transaction belongs to data port

  logic            w_grant_d;
  logic            w_xfer_ok;
  logic            w_timeout;

  // Arbitration choice, only consumed in IDLE.
  always_comb begin
    w_grant_d = 1'b0;
    if (i_req && d_req) begin
      if (RR) begin
        w_grant_d = ~r_prefer_fetch;
      end else begin
        w_grant_d = 1'b1;
      end
    end else begin
      w_grant_d = d_req;
    end
  end

  // Transfer completion; responses outside REQ/WAIT belong to an abandoned
  // transaction and are ignored.
  always_comb begin
    w_xfer_ok = 1'b0;
    case (r_state)
      ST_REQ:  w_xfer_ok = m_addr_ok & m_data_ok;
      ST_WAIT: w_xfer_ok = m_data_ok;
      default: w_xfer_ok = 1'b0;
    endcase
  end

  assign w_timeout = (r_to_cnt == TO_LAST);

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_to_cnt       <= '0;
      r_prefer_fetch <= 1'b1;
      r_owner_d      <= 1'b0;
      i_rdata        <= 32'h0000_0000;
      i_done         <= 1'b0;
      d_rdata        <= 32'h0000_0000;
      d_done         <= 1'b0;
      m_req          <= 1'b0;
      m_wr           <= 1'b0;
      m_sel          <= 4'h0;
      m_addr         <= 32'h0000_0000;
      m_wdata        <= 32'h0000_0000;
      bus_err        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses.
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_to_cnt <= '0;
          if (i_req || d_req) begin
            r_state        <= ST_REQ;
            busy           <= 1'b1;
            m_req          <= 1'b1;
            r_owner_d      <= w_grant_d;
            // The master just served yields the next tie.
            r_prefer_fetch <= w_grant_d;
            if (w_grant_d) begin
              m_wr    <= d_wr;
              m_sel   <= d_sel;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              m_wr    <= 1'b0;
              m_sel   <= 4'hF;
              m_addr  <= i_addr;
              m_wdata <= 32'h0000_0000;
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          r_to_cnt <= r_to_cnt + TO_ONE;
          // A real completion wins over a timeout in the same cycle.
          if (w_xfer_ok || w_timeout) begin
            r_state <= ST_DONE;
            m_req   <= 1'b0;
            bus_err <= ~w_xfer_ok;
            if (r_owner_d) begin
              d_done <= 1'b1;
              if (!w_xfer_ok) begin
                d_rdata <= 32'h0000_0000;
              end else if (!m_wr) begin
                d_rdata <= m_rdata;
              end
            end else begin
              i_done  <= 1'b1;
              i_rdata <= w_xfer_ok ? m_rdata : 32'h0000_0000;
            end
          end else if ((r_state == ST_REQ) && m_addr_ok) begin
            r_state <= ST_WAIT;
            m_req   <= 1'b0;
          end
        end
        ST_DONE: begin
          // Requests are not sampled here; masters drop or renew them now.
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          m_req   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Two arbiters share every input: u_rr (round-robin) and u_fx (data priority).
// A transaction-level model predicts each arbiter's outputs cycle by cycle and
// directed sequences add hand-computed expectations on top.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int unsigned TO_MAX = 255;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [3:0]  d_sel;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;

  logic [31:0] o_i_rdata [2];
  logic        o_i_done  [2];
  logic [31:0] o_d_rdata [2];
  logic        o_d_done  [2];
  logic        o_m_req   [2];
  logic        o_m_wr    [2];
  logic [3:0]  o_m_sel   [2];
  logic [31:0] o_m_addr  [2];
  logic [31:0] o_m_wdata [2];
  logic        o_bus_err [2];
  logic        o_busy    [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mem_bus_arbiter #(.RR(1'b1), .TO_MAX(255), .TO_W(8)) u_rr (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(o_i_rdata[0]), .i_done(o_i_done[0]),
    .d_req(d_req), .d_wr(d_wr), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(o_d_rdata[0]), .d_done(o_d_done[0]),
    .m_req(o_m_req[0]), .m_wr(o_m_wr[0]), .m_sel(o_m_sel[0]), .m_addr(o_m_addr[0]),
    .m_wdata(o_m_wdata[0]), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata), .bus_err(o_bus_err[0]), .busy(o_busy[0])
  );

  mem_bus_arbiter #(.RR(1'b0), .TO_MAX(255), .TO_W(8)) u_fx (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(o_i_rdata[1]), .i_done(o_i_done[1]),
    .d_req(d_req), .d_wr(d_wr), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(o_d_rdata[1]), .d_done(o_d_done[1]),
    .m_req(o_m_req[1]), .m_wr(o_m_wr[1]), .m_sel(o_m_sel[1]), .m_addr(o_m_addr[1]),
    .m_wdata(o_m_wdata[1]), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata), .bus_err(o_bus_err[1]), .busy(o_busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model (index 0 = RR, 1 = data priority)
  bit          live   [2];  // a transaction owns the bus
  bit          fin    [2];  // completion cycle being presented
  bit          acc    [2];  // bus has accepted the command
  bit          own_d  [2];
  bit          pref_f [2];  // fetch wins the next tie
  int unsigned age    [2];  // cycles spent on the bus so far
  logic [31:0] e_i_rdata [2];
  logic        e_i_done  [2];
  logic [31:0] e_d_rdata [2];
  logic        e_d_done  [2];
  logic        e_m_req   [2];
  logic        e_m_wr    [2];
  logic [3:0]  e_m_sel   [2];
  logic [31:0] e_m_addr  [2];
  logic [31:0] e_m_wdata [2];
  logic        e_bus_err [2];
  logic        e_busy    [2];

  bit fin_ok  [2];
  bit give_up [2];
  bit pick_d  [2];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      fin_ok[k]  = acc[k] ? m_data_ok : (m_addr_ok && m_data_ok);
      give_up[k] = !fin_ok[k] && ((age[k] + 1) == TO_MAX);
      if (i_req && d_req) pick_d[k] = (k == 0) ? !pref_f[k] : 1'b1;
      else                pick_d[k] = d_req;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        live[k] <= 1'b0; fin[k] <= 1'b0; acc[k] <= 1'b0; own_d[k] <= 1'b0;
        pref_f[k] <= 1'b1; age[k] <= 0;
        e_i_rdata[k] <= 32'h0; e_i_done[k] <= 1'b0; e_d_rdata[k] <= 32'h0;
        e_d_done[k] <= 1'b0; e_m_req[k] <= 1'b0; e_m_wr[k] <= 1'b0;
        e_m_sel[k] <= 4'h0; e_m_addr[k] <= 32'h0; e_m_wdata[k] <= 32'h0;
        e_bus_err[k] <= 1'b0; e_busy[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        e_i_done[k]  <= 1'b0;
        e_d_done[k]  <= 1'b0;
        e_bus_err[k] <= 1'b0;
        if (fin[k]) begin
          fin[k]    <= 1'b0;
          e_busy[k] <= 1'b0;
        end else if (!live[k]) begin
          if (i_req || d_req) begin
            live[k] <= 1'b1; acc[k] <= 1'b0; age[k] <= 0;
            own_d[k] <= pick_d[k]; pref_f[k] <= pick_d[k];
            e_busy[k] <= 1'b1; e_m_req[k] <= 1'b1;
            e_m_wr[k]    <= pick_d[k] ? d_wr : 1'b0;
            e_m_sel[k]   <= pick_d[k] ? d_sel : 4'hF;
            e_m_addr[k]  <= pick_d[k] ? d_addr : i_addr;
            e_m_wdata[k] <= pick_d[k] ? d_wdata : 32'h0;
          end
        end else begin
          age[k] <= age[k] + 1;
          if (fin_ok[k] || give_up[k]) begin
            live[k] <= 1'b0; fin[k] <= 1'b1; e_m_req[k] <= 1'b0;
            e_bus_err[k] <= give_up[k];
            if (own_d[k]) begin
              e_d_done[k] <= 1'b1;
              if (give_up[k]) e_d_rdata[k] <= 32'h0;
              else if (!e_m_wr[k]) e_d_rdata[k] <= m_rdata;
            end else begin
              e_i_done[k]  <= 1'b1;
              e_i_rdata[k] <= give_up[k] ? 32'h0 : m_rdata;
            end
          end else if (!acc[k] && m_addr_ok) begin
            acc[k] <= 1'b1; e_m_req[k] <= 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both arbiters against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d.i_rdata", k), o_i_rdata[k], e_i_rdata[k]);
        check($sformatf("u%0d.i_done", k),  {31'b0, o_i_done[k]},  {31'b0, e_i_done[k]});
        check($sformatf("u%0d.d_rdata", k), o_d_rdata[k], e_d_rdata[k]);
        check($sformatf("u%0d.d_done", k),  {31'b0, o_d_done[k]},  {31'b0, e_d_done[k]});
        check($sformatf("u%0d.m_req", k),   {31'b0, o_m_req[k]},   {31'b0, e_m_req[k]});
        check($sformatf("u%0d.m_wr", k),    {31'b0, o_m_wr[k]},    {31'b0, e_m_wr[k]});
        check($sformatf("u%0d.m_sel", k),   {28'b0, o_m_sel[k]},   {28'b0, e_m_sel[k]});
        check($sformatf("u%0d.m_addr", k),  o_m_addr[k], e_m_addr[k]);
        check($sformatf("u%0d.m_wdata", k), o_m_wdata[k], e_m_wdata[k]);
        check($sformatf("u%0d.bus_err", k), {31'b0, o_bus_err[k]}, {31'b0, e_bus_err[k]});
        check($sformatf("u%0d.busy", k),    {31'b0, o_busy[k]},    {31'b0, e_busy[k]});
      end
    end
  end

  // ---------------- directed stimulus with hand-computed expectations
  int seq0 [$];
  int seq1 [$];
  int times [$];
  int mreq_cnt;
  bit found;

  initial begin
    rst = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_wr = 1'b0;
    d_sel = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;

    // Contention from reset on a zero-wait bus.
    i_req = 1'b1; i_addr = 32'h0040_0000;
    d_req = 1'b1; d_addr = 32'h1000_0000; d_sel = 4'hF;
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hA5A5_0001;
    repeat (2) @(negedge clk);
    check("reset.busy", {31'b0, o_busy[0]}, 32'h0);
    check("reset.m_req", {31'b0, o_m_req[0]}, 32'h0);
    cmp_en = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_i_done[0]) seq0.push_back(0);
      if (o_d_done[0]) seq0.push_back(1);
      if (o_i_done[1]) seq1.push_back(0);
      if (o_d_done[1]) seq1.push_back(1);
      if (o_i_done[0] || o_d_done[0]) times.push_back(c);
      if (seq0.size() >= 4 && (o_i_done[0] || o_d_done[0])) begin
        i_req = 1'b0; d_req = 1'b0;
        break;
      end
    end
    check("rr.count", seq0.size(), 32'd4);
    for (int i = 0; i < 4 && i < seq0.size(); i++)
      check($sformatf("rr.owner%0d", i), seq0[i], i % 2);
    for (int i = 0; i < 4 && i < seq1.size(); i++)
      check($sformatf("fx.owner%0d", i), seq1[i], 32'd1);
    check("rr.first_done", (times.size() > 0) ? times[0] : -1, 32'd1);
    for (int i = 1; i < times.size(); i++)
      check($sformatf("rr.spacing%0d", i), times[i] - times[i-1], 32'd3);
    i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    @(negedge clk);

    // Fetch only with one wait state between accept and data.
    @(negedge clk); i_addr = 32'hBFC0_0000; i_req = 1'b1;           // N
    @(negedge clk);                                                  // N+1
    check("t1.m_req", {31'b0, o_m_req[0]}, 32'h1);
    check("t1.m_addr", o_m_addr[0], 32'hBFC0_0000);
    m_addr_ok = 1'b1;
    @(negedge clk); m_addr_ok = 1'b0;                                // N+2
    check("t1.wait_m_req", {31'b0, o_m_req[0]}, 32'h0);
    check("t1.wait_busy", {31'b0, o_busy[0]}, 32'h1);
    @(negedge clk); m_data_ok = 1'b1; m_rdata = 32'h3C01_0001;       // N+3
    @(negedge clk); m_data_ok = 1'b0;                                // N+4
    check("t1.i_done", {31'b0, o_i_done[0]}, 32'h1);
    check("t1.i_rdata", o_i_rdata[0], 32'h3C01_0001);
    check("t1.d_done", {31'b0, o_d_done[0]}, 32'h0);
    i_req = 1'b0;

    // Zero-wait load, then a store that must leave d_rdata untouched.
    @(negedge clk);
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1234_5678;
    d_req = 1'b1; d_wr = 1'b0; d_sel = 4'hF; d_addr = 32'h8000_0020;
    found = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (o_d_done[0]) begin
        found = 1'b1;
        check("ld.latency", c, 32'd2);
        break;
      end
    end
    check("ld.seen", {31'b0, found}, 32'h1);
    check("ld.d_rdata", o_d_rdata[0], 32'h1234_5678);
    d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_wr = 1'b1; d_sel = 4'b0011; d_addr = 32'h8000_0010;
    d_wdata = 32'hDEAD_BEEF; m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("st.m_req", {31'b0, o_m_req[0]}, 32'h1);
    check("st.m_wr", {31'b0, o_m_wr[0]}, 32'h1);
    check("st.m_sel", {28'b0, o_m_sel[0]}, 32'h3);
    check("st.m_addr", o_m_addr[0], 32'h8000_0010);
    check("st.m_wdata", o_m_wdata[0], 32'hDEAD_BEEF);
    m_addr_ok = 1'b1;
    @(negedge clk); m_addr_ok = 1'b0; m_data_ok = 1'b1;
    @(negedge clk); m_data_ok = 1'b0;
    check("st.d_done", {31'b0, o_d_done[0]}, 32'h1);
    check("st.d_rdata", o_d_rdata[0], 32'h1234_5678);
    d_req = 1'b0; d_wr = 1'b0;
    @(negedge clk);
    check("st.single_pulse", {31'b0, o_d_done[0]}, 32'h0);
    check("st.m_addr_hold", o_m_addr[0], 32'h8000_0010);

    // Timeout on a load the bus never accepts.
    d_req = 1'b1; d_addr = 32'h8000_0040; d_sel = 4'hF;
    mreq_cnt = 0; found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (o_m_req[0]) mreq_cnt++;
      if (o_d_done[0]) begin
        found = 1'b1;
        check("to.bus_err", {31'b0, o_bus_err[0]}, 32'h1);
        check("to.d_rdata", o_d_rdata[0], 32'h0);
        break;
      end
    end
    check("to.seen", {31'b0, found}, 32'h1);
    check("to.m_req_cycles", mreq_cnt, 32'd255);
    d_req = 1'b0;
    @(negedge clk); m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h5555_AAAA;
    @(negedge clk); m_addr_ok = 1'b0; m_data_ok = 1'b0;
    check("to.stray_busy", {31'b0, o_busy[0]}, 32'h0);
    check("to.stray_d_rdata", o_d_rdata[0], 32'h0);

    // Reset while waiting for data, then a fresh transfer times out on time.
    @(negedge clk); i_addr = 32'h0040_0100; i_req = 1'b1;
    @(negedge clk); m_addr_ok = 1'b1;
    @(negedge clk); m_addr_ok = 1'b0;
    repeat (100) @(negedge clk);
    check("rs.pre_busy", {31'b0, o_busy[0]}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rs.busy", {31'b0, o_busy[0]}, 32'h0);
    check("rs.m_addr", o_m_addr[0], 32'h0);
    check("rs.m_sel", {28'b0, o_m_sel[0]}, 32'h0);
    check("rs.i_rdata", o_i_rdata[0], 32'h0);
    @(negedge clk); rst = 1'b1;
    mreq_cnt = 0; found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (o_m_req[0]) mreq_cnt++;
      if (o_i_done[0]) begin
        found = 1'b1;
        check("rs.bus_err", {31'b0, o_bus_err[0]}, 32'h1);
        break;
      end
    end
    check("rs.seen", {31'b0, found}, 32'h1);
    check("rs.m_req_cycles", mreq_cnt, 32'd255);
    i_req = 1'b0;
    @(negedge clk);

    // Continuous fetches on a zero-wait bus: one completion every 3 cycles.
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h0BAD_F00D;
    i_addr = 32'h0040_0200; i_req = 1'b1;
    times.delete();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (o_i_done[0]) times.push_back(c);
      if (times.size() >= 4 && o_i_done[0]) begin
        i_req = 1'b0;
        break;
      end
    end
    check("zw.count", times.size(), 32'd4);
    for (int i = 1; i < times.size(); i++)
      check($sformatf("zw.spacing%0d", i), times[i] - times[i-1], 32'd3);
    check("zw.i_rdata", o_i_rdata[0], 32'h0BAD_F00D);
    m_addr_ok = 1'b0; m_data_ok = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
